// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants and fade helper for the LED PWM output stage
package led_pkg;

    localparam int PWM_STEPS = 15;
    localparam int DUTY_W    = 4;
    localparam int NUM_LEDS  = 12;

    typedef logic [DUTY_W-1:0] duty_t;

    // Moves one step toward the target; never overshoots and never wraps
    function automatic duty_t step_toward(input duty_t cur, input duty_t tgt);
        if (tgt > cur)
            return cur + duty_t'(1);
        else if (tgt < cur)
            return cur - duty_t'(1);
        return cur;
    endfunction

endpackage

// File: rtl/led_pwm_driver_if.sv
// rtl/led_pwm_driver_if.sv - sequencer-to-LED-driver signal bundle
interface led_pwm_driver_if;
    import led_pkg::*;

    logic [NUM_LEDS:1] vec;
    logic [DUTY_W:1]   pwm1;
    logic [DUTY_W:1]   pwm2;
    logic [NUM_LEDS:1] led;
    logic              period_start;
    logic [DUTY_W:1]   level1;
    logic [DUTY_W:1]   level2;

    modport master (output vec, pwm1, pwm2,
                    input  led, period_start, level1, level2);
    modport slave  (input  vec, pwm1, pwm2,
                    output led, period_start, level1, level2);

endinterface

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - prescaler and 15-step phase counter for PWM output stages
module pwm_timebase
    import led_pkg::*;
#(
    parameter int PRESCALE = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic [DUTY_W:1] phase,
    output logic            tick,
    output logic            boundary
);

    localparam int              PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRE_MAX   = PW'(PRESCALE - 1);
    localparam logic [DUTY_W:1] PHASE_MAX = DUTY_W'(PWM_STEPS - 1);

    logic [PW-1:0] presc;

    assign tick     = (presc == PRE_MAX);
    assign boundary = tick && (phase == PHASE_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            phase <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (boundary)
                phase <= '0;
            else if (tick)
                phase <= phase + 1'b1;
        end
    end

endmodule

// File: rtl/led_pwm_driver.sv
// rtl/led_pwm_driver.sv - double-buffered 12-LED PWM driver with optional per-group fade
module led_pwm_driver
    import led_pkg::*;
#(
    parameter int PRESCALE = 16,
    parameter int SPLIT    = 6,
    parameter int FADE     = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    led_pwm_driver_if.slave   bus
);

    logic [DUTY_W:1]   phase;
    logic              tick_unused;
    logic              boundary;

    logic [NUM_LEDS:1] mask;
    logic [DUTY_W:1]   lvl1;
    logic [DUTY_W:1]   lvl2;
    logic [NUM_LEDS:1] led_q;
    logic [NUM_LEDS:1] led_d;
    logic              start_q;

    pwm_timebase #(.PRESCALE(PRESCALE)) u_timebase (
        .clk      (clk),
        .reset_n  (reset_n),
        .phase    (phase),
        .tick     (tick_unused),
        .boundary (boundary)
    );

    always_comb begin
        led_d = '0;
        for (int i = 1; i <= NUM_LEDS; i++)
            led_d[i] = mask[i] && (phase < ((i <= SPLIT) ? lvl1 : lvl2));
    end

    // Inputs are sampled only on the period boundary so a running pulse is never truncated
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask    <= '0;
            lvl1    <= '0;
            lvl2    <= '0;
            led_q   <= '0;
            start_q <= 1'b0;
        end else begin
            led_q   <= led_d;
            start_q <= boundary;
            if (boundary) begin
                mask <= bus.vec;
                if (FADE != 0) begin
                    lvl1 <= step_toward(lvl1, bus.pwm1);
                    lvl2 <= step_toward(lvl2, bus.pwm2);
                end else begin
                    lvl1 <= bus.pwm1;
                    lvl2 <= bus.pwm2;
                end
            end
        end
    end

    assign bus.led          = led_q;
    assign bus.period_start = start_q;
    assign bus.level1       = lvl1;
    assign bus.level2       = lvl2;

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb/tb_led_pwm_driver.sv - directed self-checking bench for led_pwm_driver
module tb_led_pwm_driver;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    led_pwm_driver_if if0 ();
    led_pwm_driver_if if1 ();
    led_pwm_driver_if if2 ();

    led_pwm_driver #(.PRESCALE(2), .SPLIT(6), .FADE(0)) u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
    led_pwm_driver #(.PRESCALE(2), .SPLIT(6), .FADE(1)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    led_pwm_driver #(.PRESCALE(1), .SPLIT(6), .FADE(0)) u2 (.clk(clk), .reset_n(reset_n), .bus(if2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    // Phase held after edge j with PRESCALE = 2
    function automatic int ph2(input int j);
        return (j % 30) / 2;
    endfunction

    // u0: FFF/15 from reset, 004/5 applied at edge 90, pwm1 = 10 applied at edge 150
    function automatic logic [12:1] exp0(input int k);
        int j;
        int lvl;
        logic [12:1] m;
        j = k - 1;
        if (j < 30)       begin m = 12'h000; lvl = 0;  end
        else if (j < 90)  begin m = 12'hFFF; lvl = 15; end
        else if (j < 150) begin m = 12'h004; lvl = 5;  end
        else              begin m = 12'h004; lvl = 10; end
        return (ph2(j) < lvl) ? (m & 12'h03F) : 12'h000;
    endfunction

    // u1 group 2: ramps 0 -> 15 over 15 boundaries, then down to 3 and holds
    function automatic int lvl_u1(input int j);
        int n;
        n = j / 30;
        if (n <= 15)
            return n;
        return (30 - n > 3) ? 30 - n : 3;
    endfunction

    function automatic logic [12:1] exp1(input int k);
        int j;
        j = k - 1;
        if (j < 30)
            return 12'h000;
        return (ph2(j) < lvl_u1(j)) ? 12'hFC0 : 12'h000;
    endfunction

    function automatic logic [12:1] exp2(input int k);
        int j;
        j = k - 1;
        return (j >= 15 && (j % 15) == 0) ? 12'h001 : 12'h000;
    endfunction

    initial begin
        int bad0 = 0, bad1 = 0, bad2 = 0, badps = 0, badl = 0, bad3 = 0;
        int hi_a = 0, hi_b = 0;

        reset_n  = 1'b0;
        if0.vec  = 12'hFFF; if0.pwm1 = 4'd15; if0.pwm2 = 4'd0;
        if1.vec  = 12'hFFF; if1.pwm1 = 4'd0;  if1.pwm2 = 4'd15;
        if2.vec  = 12'h001; if2.pwm1 = 4'd1;  if2.pwm2 = 4'd0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_led", {20'd0, if0.led}, 32'd0);
        check("rst_level1", {28'd0, if0.level1}, 32'd0);
        check("rst_period_start", {31'd0, if0.period_start}, 32'd0);
        check("rst_level2_fade", {28'd0, if1.level2}, 32'd0);
        reset_n = 1'b1;

        for (int k = 1; k <= 859; k++) begin
            tick1();
            if (if0.led !== exp0(k)) bad0++;
            if (if1.led !== exp1(k)) bad1++;
            if (if2.led !== exp2(k)) bad2++;
            if (if1.level2 !== 4'(lvl_u1(k))) badl++;
            if (if0.period_start !== (k % 30 == 0)) badps++;
            if (if1.period_start !== (k % 30 == 0)) badps++;
            if (if2.period_start !== (k % 15 == 0)) badps++;
            if (k >= 121 && k <= 150 && if0.led[3]) hi_a++;
            if (k >= 151 && k <= 180 && if0.led[3]) hi_b++;

            if (k == 29)  check("level1_before_boundary", {28'd0, if0.level1}, 32'd0);
            if (k == 30)  check("level1_at_boundary", {28'd0, if0.level1}, 32'd15);
            if (k == 60) begin
                if0.vec  = 12'h004;
                if0.pwm1 = 4'd5;
            end
            if (k == 134) if0.pwm1 = 4'd10;
            if (k == 149) check("level1_held_mid_change", {28'd0, if0.level1}, 32'd5);
            if (k == 150) check("level1_new_duty", {28'd0, if0.level1}, 32'd10);
            if (k == 449) check("fade_level2_14", {28'd0, if1.level2}, 32'd14);
            if (k == 450) begin
                check("fade_level2_15", {28'd0, if1.level2}, 32'd15);
                if1.pwm2 = 4'd3;
            end
            if (k == 780) check("fade_level2_4", {28'd0, if1.level2}, 32'd4);
            if (k == 810) check("fade_level2_3", {28'd0, if1.level2}, 32'd3);
            if (k == 840) check("fade_no_overshoot", {28'd0, if1.level2}, 32'd3);
        end

        check("u0_led_trace", bad0, 0);
        check("u1_led_trace", bad1, 0);
        check("u2_prescale1_led_trace", bad2, 0);
        check("u1_level2_trace", badl, 0);
        check("period_start_trace", badps, 0);
        check("duty5_high_cycles", hi_a, 10);
        check("duty10_high_cycles", hi_b, 20);
        check("lit_before_reset", {20'd0, if0.led}, 32'h004);

        // Reset at phase 9 while lit: outputs must clear without a clock edge
        reset_n = 1'b0;
        #1;
        check("async_rst_led", {20'd0, if0.led}, 32'd0);
        check("async_rst_level1", {28'd0, if0.level1}, 32'd0);
        check("async_rst_level2", {28'd0, if1.level2}, 32'd0);
        check("async_rst_period_start", {31'd0, if0.period_start}, 32'd0);

        repeat (2) @(posedge clk);
        #1;
        if0.vec  = 12'h801;
        if0.pwm1 = 4'd15;
        if0.pwm2 = 4'd15;
        reset_n  = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            tick1();
            if (if0.led !== ((k >= 31) ? 12'h801 : 12'h000)) bad3++;
            if (if0.period_start !== (k == 30)) bad3++;
            if (k == 30) check("post_rst_level2", {28'd0, if0.level2}, 32'd15);
        end
        check("post_rst_dark_then_apply", bad3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pwm_driver.md
Name: led_pwm_driver

Overview:
- Downstream consumer of the microcode sequencer: takes its 12-bit LED enable vector and two 4-bit brightness levels and drives 12 physical LED pins with glitch-free PWM.
- Inputs are double-buffered and take effect only at PWM period boundaries, so sequencer step changes never cut a pulse short.
- Optional per-group fade ramps brightness one step per period toward the commanded level.

Parameters:
- PRESCALE, 16, clk cycles per PWM phase tick; legal range 1..65535.
- SPLIT, 6, LEDs 1..SPLIT use level group 1; LEDs SPLIT+1..12 use group 2.
- FADE, 1, 1 = ramp active level toward target by ±1 per period; 0 = jump to target at the boundary.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- vec  in  [12:1]  LED enable mask from the sequencer; bit i enables led[i].
- pwm1  in  [4:1]  target duty for group 1, 0..15.
- pwm2  in  [4:1]  target duty for group 2, 0..15.
- led  out  [12:1]  registered LED drive, active high.
- period_start  out  1  one-cycle pulse in the first clk cycle of each PWM period.
- level1  out  [4:1]  current active duty of group 1.
- level2  out  [4:1]  current active duty of group 2.

Behaviour:
- Reset (asynchronous, while reset_n = 0):
  - led, period_start, level1, level2, shadow mask, prescaler and phase are all 0.
  - LEDs stay dark until the first boundary after reset release.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - tick = (prescaler == PRESCALE-1). With PRESCALE = 1, tick is high every cycle.
- Phase counter:
  - 4 bits, range 0..14, giving 15 steps per period. Advances on tick.
  - boundary = tick && phase == 14. On boundary, phase -> 0.
  - Period length is 15*PRESCALE clk cycles.
- On boundary (same edge):
  - Shadow mask <= vec.
  - FADE = 0: levelN <= pwmN.
  - FADE = 1: levelN <= levelN+1 if pwmN > levelN; levelN-1 if pwmN < levelN; otherwise unchanged. Never overshoots and never wraps.
  - period_start is asserted (registered) in the following cycle, i.e. the first cycle with phase = 0.
- Output:
  - led[i] is registered as mask[i] && (phase < level_g(i)), computed from the current registered phase, mask and level.
  - led therefore lags a phase change by one clk cycle.
  - Duty 0 = LED never on. Duty 15 = continuously on, no gap at the period wrap.
  - Duty d gives exactly d*PRESCALE high cycles per period.
- Input changes between boundaries are ignored. Only the value present on the boundary edge is used. vec/pwm changes made on the sequencer's negedge are stable at the next rising edge.
- Simultaneous vec and pwm change at a boundary: both take effect in the same period.
- Reset asserted mid-period: all outputs go low immediately (asynchronously). After release, the driver restarts at prescaler = 0, phase = 0, with a dark first period.
- Width rules: comparisons are unsigned 4-bit. The prescaler width is $clog2(PRESCALE), minimum 1 bit.

Decomposition:
- Shared package led_pkg:
  - Constants PWM_STEPS = 15, DUTY_W = 4, NUM_LEDS = 12.
  - Function step_toward(cur, tgt) returning the faded level.
- Sub-module pwm_timebase, containing the prescaler and phase counter.
  - Parameter: PRESCALE.
  - Outputs: phase[4:1], tick, boundary.
  - Reusable by future LED output stages.
- The top level holds the shadow mask, the level registers, the comparators and the output registers.

Test Plan (PRESCALE = 2, SPLIT = 6):
- FADE = 0; vec = 12'hFFF, pwm1 = 15, pwm2 = 0 held from reset release -> after the first boundary, led[6:1] are continuously 1 and led[12:7] continuously 0. period_start pulses every 30 cycles.
- FADE = 0; vec = 12'h004, pwm1 = 5 -> led[3] is high for exactly 10 of every 30 cycles, starting one cycle after phase 0. All other LEDs stay 0.
- FADE = 0; change pwm1 from 5 to 10 at phase 7 -> the current period keeps 10 high cycles; the next period shows 20 high cycles. level1 changes only at the boundary.
- FADE = 1; pwm2 stepped from 0 to 15 -> level2 increments by 1 per period and reaches 15 after 15 boundaries. Stepping back to 3 decrements level2 to 3 over 12 periods, with no overshoot.
- Pull reset_n low at phase 9 with LEDs lit -> led, level1/2 and period_start drop to 0 without waiting for clk. After release, LEDs stay dark for 30 cycles, then the new inputs apply.
- PRESCALE = 1, duty 1 on led[1] -> exactly 1 high cycle per 15-cycle period; boundary timing is correct with tick high every cycle.
